// File: rtl/sci_acc_pkt_queue.sv
// Packet queue in front of sci_acc_top: FIFO of one-hot-mode packets with
// single-in-flight issue, bounded retry on drop and saturating outcome counters.
module sci_acc_pkt_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int RES_WIDTH  = 8,
  parameter int DEPTH      = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_MODES-1:0]  in_mode,
  input  logic [RES_WIDTH-1:0]  in_res,
  output logic                  in_ready,
  output logic                  in_err,
  output logic                  pkt_valid,
  output logic [DATA_WIDTH-1:0] op_pkt__data,
  output logic [NUM_MODES-1:0]  op_pkt__mode,
  output logic [RES_WIDTH-1:0]  op_pkt__res,
  input  logic                  ready,
  input  logic                  pkt_dropd,
  input  logic                  done,
  output logic                  drop_evt,
  output logic [15:0]           issued_cnt,
  output logic [15:0]           dropped_cnt,
  output logic                  busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = DATA_WIDTH + NUM_MODES + RES_WIDTH;
  localparam int RTW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [RTW-1:0]  retry_reg, retry_next;
  logic            in_err_reg, drop_evt_reg, drop_evt_next;
  logic [15:0]     issued_reg, dropped_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;

  logic mode_onehot, push, pop, issue_inc, drop_inc, more_after_pop;

  assign mode_onehot = (in_mode != '0) && ((in_mode & (in_mode - NUM_MODES'(1))) == '0);
  assign in_ready    = count_reg < CW'(DEPTH);
  assign push        = in_valid && in_ready && mode_onehot;
  // A same-cycle push keeps the queue non-empty even when the last entry pops.
  assign more_after_pop = (count_reg > CW'(1)) || push;

  always_comb begin
    state_next    = state_reg;
    retry_next    = retry_reg;
    pop           = 1'b0;
    issue_inc     = 1'b0;
    drop_inc      = 1'b0;
    drop_evt_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = ISSUE;
          retry_next = '0;
        end
      end
      ISSUE: begin
        if (ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          pop        = 1'b1;
          issue_inc  = 1'b1;
          retry_next = '0;
          state_next = more_after_pop ? ISSUE : IDLE;
        end else if (pkt_dropd) begin
          if (retry_reg < RTW'(MAX_RETRY)) begin
            retry_next = retry_reg + RTW'(1);
            state_next = ISSUE;
          end else begin
            pop           = 1'b1;
            drop_inc      = 1'b1;
            drop_evt_next = 1'b1;
            retry_next    = '0;
            state_next    = more_after_pop ? ISSUE : IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      retry_reg    <= '0;
      in_err_reg   <= 1'b0;
      drop_evt_reg <= 1'b0;
      issued_reg   <= '0;
      dropped_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      retry_reg    <= retry_next;
      in_err_reg   <= in_valid && in_ready && !mode_onehot;
      drop_evt_reg <= drop_evt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (issue_inc && issued_reg != 16'hFFFF) issued_reg <= issued_reg + 16'd1;
      if (drop_inc && dropped_reg != 16'hFFFF) dropped_reg <= dropped_reg + 16'd1;
    end
  end

  // Storage carries no reset; its contents are only exposed while pkt_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_data, in_mode, in_res};
  end

  assign head      = mem[rd_ptr_reg];
  assign pkt_valid = (state_reg == ISSUE);
  assign {op_pkt__data, op_pkt__mode, op_pkt__res} = pkt_valid ? head : '0;

  assign in_err      = in_err_reg;
  assign drop_evt    = drop_evt_reg;
  assign issued_cnt  = issued_reg;
  assign dropped_cnt = dropped_reg;
  assign busy        = (count_reg != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_sci_acc_pkt_queue.sv
// Directed bench for sci_acc_pkt_queue: issue latency, fill/back-pressure,
// mode rejection, retry/drop, done+drop collision and mid-flight reset.
module tb_sci_acc_pkt_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_mode;
  logic [7:0]  in_res;
  logic        in_ready, in_err, pkt_valid;
  logic [31:0] op_pkt__data;
  logic [3:0]  op_pkt__mode;
  logic [7:0]  op_pkt__res;
  logic        ready, pkt_dropd, done, drop_evt, busy;
  logic [15:0] issued_cnt, dropped_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sci_acc_pkt_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_mode      (in_mode),
    .in_res       (in_res),
    .in_ready     (in_ready),
    .in_err       (in_err),
    .pkt_valid    (pkt_valid),
    .op_pkt__data (op_pkt__data),
    .op_pkt__mode (op_pkt__mode),
    .op_pkt__res  (op_pkt__res),
    .ready        (ready),
    .pkt_dropd    (pkt_dropd),
    .done         (done),
    .drop_evt     (drop_evt),
    .issued_cnt   (issued_cnt),
    .dropped_cnt  (dropped_cnt),
    .busy         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] d, input logic [3:0] m, input logic [7:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_res   = r;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_res = '0;
    ready = 1'b0; pkt_dropd = 1'b0; done = 1'b0;

    // Reset values
    #3;
    chk_bit("rst_pkt_valid", pkt_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_in_err", in_err, 1'b0);
    chk_bit("rst_drop_evt", drop_evt, 1'b0);
    chk_val("rst_issued", 32'(issued_cnt), 32'd0);
    chk_val("rst_dropped", 32'(dropped_cnt), 32'd0);
    chk_val("rst_op_data", op_pkt__data, 32'd0);
    step(); step();
    rst_n = 1'b0;

    // Single packet, first edge after reset release, done 3 cycles after accept
    ready = 1'b1;
    offer(32'h1234, 4'b0010, 8'd8);
    chk_bit("lat_push_no_valid", pkt_valid, 1'b0);
    chk_bit("lat_push_busy", busy, 1'b1);
    step();
    chk_bit("lat_issue_valid", pkt_valid, 1'b1);
    chk_val("lat_data", op_pkt__data, 32'h1234);
    chk_val("lat_mode", 32'(op_pkt__mode), 32'h2);
    chk_val("lat_res", 32'(op_pkt__res), 32'd8);
    step();
    chk_bit("accept_valid_low", pkt_valid, 1'b0);
    step();
    step();
    chk_bit("wait_valid_low", pkt_valid, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_val("single_issued", 32'(issued_cnt), 32'd1);
    chk_bit("single_busy_low", busy, 1'b0);

    // Non-one-hot modes rejected
    offer(32'hDEAD, 4'b0110, 8'd1);
    chk_bit("err_multi_pulse", in_err, 1'b1);
    step();
    chk_bit("err_multi_clear", in_err, 1'b0);
    offer(32'hBEEF, 4'b0000, 8'd2);
    chk_bit("err_zero_pulse", in_err, 1'b1);
    step();
    chk_bit("err_zero_clear", in_err, 1'b0);
    chk_bit("err_no_push", busy, 1'b0);

    // Fill past DEPTH with ready low
    ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      in_mode  = 4'(1 << (i % 4));
      in_res   = 8'(i);
      #1;
      chk_bit("fill_in_ready", in_ready, (i < 8));
      step();
    end
    in_valid = 1'b0;
    chk_bit("full_in_ready", in_ready, 1'b0);
    chk_bit("full_valid", pkt_valid, 1'b1);
    chk_val("full_head_data", op_pkt__data, 32'h100);
    step(); step();
    chk_bit("hold_valid", pkt_valid, 1'b1);
    chk_val("hold_head_data", op_pkt__data, 32'h100);
    chk_val("hold_head_mode", 32'(op_pkt__mode), 32'h1);
    chk_val("hold_head_res", 32'(op_pkt__res), 32'd0);

    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_bit("drain_valid", pkt_valid, 1'b1);
      chk_val("drain_data", op_pkt__data, 32'h100 + 32'(i));
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    chk_bit("drain_ninth_rejected", busy, 1'b0);
    chk_val("drain_issued", 32'(issued_cnt), 32'd9);

    // Drop on every attempt: 1 issue + 3 retries, then discard
    offer(32'hAAAA, 4'b0001, 8'd1);
    offer(32'hBBBB, 4'b0100, 8'd2);
    for (int a = 0; a < 4; a++) begin
      chk_bit("retry_valid", pkt_valid, 1'b1);
      chk_val("retry_data", op_pkt__data, 32'hAAAA);
      chk_bit("retry_no_drop_evt", drop_evt, 1'b0);
      step();
      chk_bit("retry_wait_low", pkt_valid, 1'b0);
      pkt_dropd = 1'b1;
      step();
      pkt_dropd = 1'b0;
    end
    chk_bit("drop_evt_pulse", drop_evt, 1'b1);
    chk_val("drop_count", 32'(dropped_cnt), 32'd1);
    chk_bit("next_valid", pkt_valid, 1'b1);
    chk_val("next_data", op_pkt__data, 32'hBBBB);
    step();
    chk_bit("drop_evt_clear", drop_evt, 1'b0);

    // done and pkt_dropd together count as done
    done = 1'b1; pkt_dropd = 1'b1;
    step();
    done = 1'b0; pkt_dropd = 1'b0;
    chk_val("both_issued", 32'(issued_cnt), 32'd10);
    chk_val("both_dropped", 32'(dropped_cnt), 32'd1);
    chk_bit("both_no_retry", pkt_valid, 1'b0);
    chk_bit("both_idle", busy, 1'b0);

    // Reset while waiting with three entries queued
    offer(32'hC0, 4'b1000, 8'd3);
    offer(32'hD0, 4'b0001, 8'd4);
    offer(32'hE0, 4'b0010, 8'd5);
    chk_bit("pre_rst_busy", busy, 1'b1);
    chk_bit("pre_rst_wait", pkt_valid, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_val("mid_rst_issued", 32'(issued_cnt), 32'd0);
    chk_val("mid_rst_dropped", 32'(dropped_cnt), 32'd0);
    chk_bit("mid_rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk_val("post_rst_done_ignored", 32'(issued_cnt), 32'd0);
    chk_bit("post_rst_idle", busy, 1'b0);
    offer(32'hF0, 4'b0100, 8'd6);
    step();
    chk_bit("post_rst_valid", pkt_valid, 1'b1);
    chk_val("post_rst_head", op_pkt__data, 32'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sci_acc_pkt_queue.md
SCI_ACC_PKT_QUEUE -- requirements
Module: sci_acc_pkt_queue

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand data width; matches sci_acc_top.
REQ-002 Parameter NUM_MODES, 4, one-hot mode field width; matches sci_acc_top.
REQ-003 Parameter RES_WIDTH, 8, resolution field width; matches sci_acc_top.
REQ-004 Parameter DEPTH, 8, FIFO entries; power of two, >=2.
REQ-005 Parameter MAX_RETRY, 3, re-issues allowed after a pkt_dropd before the packet is discarded.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-high (1 = in reset).
REQ-008 in_valid  in  1  producer offers a packet.
REQ-009 in_data / in_mode / in_res  in  DATA_WIDTH / NUM_MODES / RES_WIDTH  offered packet fields.
REQ-010 in_ready  out  1  queue can accept; combinational = (count < DEPTH).
REQ-011 in_err  out  1  one-cycle pulse: offered packet rejected for non-one-hot in_mode.
REQ-012 pkt_valid  out  1  packet presented to sci_acc_top.
REQ-013 op_pkt__data / op_pkt__mode / op_pkt__res  out  DATA_WIDTH / NUM_MODES / RES_WIDTH  head-of-queue fields.
REQ-014 ready / pkt_dropd / done  in  1 each  from sci_acc_top: accept, drop pulse, completion pulse.
REQ-015 drop_evt  out  1  one-cycle pulse: packet discarded after retries exhausted.
REQ-016 issued_cnt / dropped_cnt  out  16 each  saturating counts of completed / discarded packets.
REQ-017 busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-018 Push when in_valid && in_ready && in_mode one-hot; write at tail, count+1 next cycle.
REQ-019 in_valid && in_ready && in_mode not one-hot (zero or >1 bits): no push, in_err=1 next cycle.
REQ-020 Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-021 FSM states IDLE, ISSUE, WAIT_DONE; reset state IDLE.
REQ-022 IDLE -> ISSUE when FIFO non-empty; retry counter cleared on entry to ISSUE from IDLE.
REQ-023 ISSUE: pkt_valid=1, op_pkt__* = head entry, held stable until ready=1 on the same edge; then -> WAIT_DONE, pkt_valid=0 next cycle.
REQ-024 Outside ISSUE pkt_valid=0; at most one packet in flight.
REQ-025 WAIT_DONE + done=1: pop head, issued_cnt+1, -> ISSUE if count after pop >0, else IDLE.
REQ-026 WAIT_DONE + pkt_dropd=1 (done=0): if retry<MAX_RETRY, retry+1, -> ISSUE, same head re-presented; else pop head, dropped_cnt+1, drop_evt=1 next cycle, -> ISSUE/IDLE as REQ-025.
REQ-027 done and pkt_dropd together: treated as done only.
REQ-028 done or pkt_dropd outside WAIT_DONE: ignored.
REQ-029 Push and pop same cycle: count unchanged, both pointers advance; at full, in_ready=0 so push rejected.
REQ-030 Counters saturate at 16'hFFFF, never wrap.
REQ-031 Latency: packet pushed into empty queue with ready=1 sees pkt_valid=1 on cycle 2 after push edge (push, IDLE->ISSUE).

Reset
REQ-032 rst_n=1 asynchronously: FSM IDLE, pointers/count/retry 0, pkt_valid 0, in_err 0, drop_evt 0, counters 0, busy 0; op_pkt__* 0.
REQ-033 Reset mid-operation discards all queued and in-flight packets; no done/drop counted for them.
REQ-034 First push permitted on first rising edge after rst_n falls to 0.

Verification
REQ-035 Push data=0x1234, mode=4'b0010, res=8 with ready=1, done 3 cycles after accept -> pkt_valid one cycle, fields match, issued_cnt=1, busy low after.
REQ-036 Push DEPTH+1 packets with ready=0 -> in_ready=0 after 8th, 9th rejected, pkt_valid held with head fields stable.
REQ-037 pkt_dropd on every attempt with MAX_RETRY=3 -> 4 issues of same packet, then drop_evt pulse, dropped_cnt=1, next packet issued.
REQ-038 in_mode=4'b0110 and 4'b0000 offered -> in_err pulses twice, count stays 0.
REQ-039 done and pkt_dropd same cycle -> issued_cnt+1, dropped_cnt unchanged, no retry.
REQ-040 Assert rst_n in WAIT_DONE with 3 entries queued -> all outputs to reset values immediately; later done ignored.
